// File: rtl/bus_rr_arbiter_if.sv
// Bus arbitration interface: requester levels in, registered one-hot grant out.
// master = requester side, slave = arbiter side.
interface bus_rr_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
);
  logic [NREQ-1:0] bus_req;
  logic [NREQ-1:0] bus_gnt;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;
  logic            starved;

  modport master (output bus_req, input bus_gnt, gnt_valid, gnt_idx, starved);
  modport slave  (input bus_req, output bus_gnt, gnt_valid, gnt_idx, starved);
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with bounded burst hold and starvation guard.
//
//   state | meaning
//   ------+---------------------------------------------
//   IDLE  | no grant outstanding
//   OWN   | grant held by requester rr_ptr_q
//
// The first grant after reset scans from index 0 (fresh_q), so a reset with
// every request high always restarts at requester 0; afterwards the scan
// starts one past the last granted index.
module bus_rr_arbiter #(
  parameter int NREQ       = 2,
  parameter int IDXW       = 1,
  parameter int MAXHOLD    = 4,
  parameter int STARVE_LIM = 6
) (
  input  logic            clock,
  input  logic            reset,
  bus_rr_arbiter_if.slave arb
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]      hold_q, hold_d;
  logic [3:0]      wait_q [NREQ];
  logic [3:0]      wait_d [NREQ];
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            starved_q, starved_d;
  logic            fresh_q, fresh_d;

  logic [NREQ-1:0] req;
  logic            own;
  logic            other_req;
  logic            starve_hit;
  logic [IDXW-1:0] starve_idx;
  logic            rot_hit;
  logic [IDXW-1:0] rot_idx;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] cand_idx;
  logic            stay;
  logic            issue;
  int              cand;

  assign req = arb.bus_req;
  assign own = (state_q == OWN);

  // State and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      starved_q <= 1'b0;
      fresh_q   <= 1'b1;
      for (int i = 0; i < NREQ; i++) wait_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      starved_q <= starved_d;
      fresh_q   <= fresh_d;
      for (int i = 0; i < NREQ; i++) wait_q[i] <= wait_d[i];
    end
  end

  // Candidate search: starved requesters first (lowest index), else rotation.
  // While owning, the current owner is excluded from both searches.
  always_comb begin
    other_req  = 1'b0;
    starve_hit = 1'b0;
    starve_idx = '0;
    rot_hit    = 1'b0;
    rot_idx    = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && !(own && (IDXW'(i) == rr_ptr_q))) begin
        other_req = 1'b1;
        if (wait_q[i] == 4'(STARVE_LIM)) begin
          starve_hit = 1'b1;
          starve_idx = IDXW'(i);
        end
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      cand     = fresh_q ? k : (int'(rr_ptr_q) + 1 + k) % NREQ;
      cand_idx = IDXW'(cand);
      if (!rot_hit && req[cand_idx] && !(own && (cand_idx == rr_ptr_q))) begin
        rot_hit = 1'b1;
        rot_idx = cand_idx;
      end
    end
    pick_idx = starve_hit ? starve_idx : rot_idx;
    stay     = own && req[rr_ptr_q] && (hold_q < 4'(MAXHOLD)) && !starve_hit;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = OWN;
      OWN:     if (!stay && !other_req && !req[rr_ptr_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, pointer, hold and wait counter updates.
  always_comb begin
    gnt_d     = '0;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    starved_d = 1'b0;
    fresh_d   = fresh_q;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          issue     = 1'b1;
          hold_d    = 4'd1;
          starved_d = starve_hit;
        end else begin
          hold_d = '0;
        end
      end
      OWN: begin
        if (stay) begin
          gnt_d  = gnt_q;
          hold_d = hold_q + 4'd1;
        end else if (other_req) begin
          issue     = 1'b1;
          hold_d    = 4'd1;
          starved_d = starve_hit;
        end else if (req[rr_ptr_q]) begin
          gnt_d  = gnt_q;
          hold_d = 4'd1;
        end else begin
          hold_d = '0;
        end
      end
      default: hold_d = '0;
    endcase
    if (issue) begin
      gnt_d    = NREQ'(1) << pick_idx;
      rr_ptr_d = pick_idx;
      fresh_d  = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i] || !req[i])               wait_d[i] = '0;
      else if (wait_q[i] < 4'(STARVE_LIM))  wait_d[i] = wait_q[i] + 4'd1;
      else                                  wait_d[i] = wait_q[i];
    end
  end

  assign arb.bus_gnt   = gnt_q;
  assign arb.gnt_valid = |gnt_q;
  assign arb.gnt_idx   = rr_ptr_q;
  assign arb.starved   = starved_q;

endmodule
